// File: rtl/adc_cfg_seq.sv
// ---------------------------------------------------------------------------
// adc_cfg_seq - power-up configuration sequencer for the ADC register port.
//
// Walks a registered lookup table of {addr[12:0], data[7:0]} entries and
// issues one register write per entry on the adc_spi command port. An entry
// whose address is 13'h1FFF terminates the table early. With verify built in,
// every write is read back and compared; a mismatch rewrites the entry up to
// MAX_RETRY more times before the sequencer stops in ERR.
//
// Build option:
//   ADC_CFG_VERIFY_EN  - defined: READ/CHECK states, retry counter, ERR path.
//                        undefined: write-only; cmd_read, read_addr, error
//                        and err_index are tied 0.
//
// Parameters: LUT_DEPTH (1..256), INIT_DELAY (>=1), MAX_RETRY (0..15)
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start                 re-run pulse, honoured in IDLE/DONE/ERR only
//   busy, done, error     status levels; err_index = failing entry
//   lut_index, lut_data   table address out, table word in (1 cycle later)
//   cmd_write/cmd_read    requests, held until the matching 1-cycle ack
//   write_addr/write_data/read_addr, read_data   command payload
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module adc_cfg_seq #(
    parameter int LUT_DEPTH  = 16,
    parameter int INIT_DELAY = 1000,
    parameter int MAX_RETRY  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  err_index,
    output logic [7:0]  lut_index,
    input  logic [20:0] lut_data,
    output logic        cmd_write,
    output logic        cmd_read,
    input  logic        cmd_write_ack,
    input  logic        cmd_read_ack,
    output logic [12:0] write_addr,
    output logic [7:0]  write_data,
    output logic [12:0] read_addr,
    input  logic [7:0]  read_data
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_INIT  = 4'd1,
        S_FETCH = 4'd2,
        S_LATCH = 4'd3,
        S_WRITE = 4'd4,
        S_READ  = 4'd5,
        S_CHECK = 4'd6,
        S_NEXT  = 4'd7,
        S_DONE  = 4'd8,
        S_ERR   = 4'd9
    } state_e;

    localparam int               CNT_W     = (INIT_DELAY > 1) ? $clog2(INIT_DELAY) : 1;
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_DELAY - 1);
    localparam logic [7:0]       LAST_IDX  = 8'(LUT_DEPTH - 1);
    localparam logic [12:0]      TERM_ADDR = 13'h1FFF;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       lut_index_q, lut_index_d;
    logic [12:0]      waddr_q, waddr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             cmd_write_q, cmd_write_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic wr_ack, start_ok, init_last, last_entry, is_term;

    // Acks only count while our request is actually up.
    assign wr_ack     = cmd_write_q & cmd_write_ack;
    assign start_ok   = start & ((state_q == S_IDLE) | (state_q == S_DONE) | (state_q == S_ERR));
    assign init_last  = (cnt_q == INIT_LAST);
    assign last_entry = (lut_index_q == LAST_IDX);
    assign is_term    = (lut_data[20:8] == TERM_ADDR);

`ifdef ADC_CFG_VERIFY_EN
    logic [12:0] raddr_q, raddr_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [3:0]  retry_q, retry_d;
    logic        cmd_read_q, cmd_read_d;
    logic        error_q, error_d;
    logic [7:0]  err_index_q, err_index_d;
    logic        rd_ack, rd_match, can_retry;

    assign rd_ack    = cmd_read_q & cmd_read_ack;
    assign rd_match  = (rdata_q == wdata_q);
    assign can_retry = (retry_q < 4'(MAX_RETRY));
`endif

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_INIT;
        else        state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (init_last) state_d = S_FETCH;
            S_FETCH: state_d = S_LATCH;
            S_LATCH: state_d = is_term ? S_DONE : S_WRITE;
`ifdef ADC_CFG_VERIFY_EN
            S_WRITE: if (wr_ack) state_d = S_READ;
            S_READ:  if (rd_ack) state_d = S_CHECK;
            S_CHECK: begin
                if (rd_match)       state_d = S_NEXT;
                else if (can_retry) state_d = S_WRITE;
                else                state_d = S_ERR;
            end
            S_ERR:   if (start) state_d = S_FETCH;
`else
            S_WRITE: if (wr_ack) state_d = S_NEXT;
`endif
            S_NEXT:  state_d = last_entry ? S_DONE : S_FETCH;
            S_IDLE,
            S_DONE:  if (start) state_d = S_FETCH;
            default: state_d = S_IDLE;   // unreachable encodings recover to IDLE
        endcase
    end

    // ---------------- output / datapath next values ----------------
    always_comb begin
        cnt_d       = cnt_q;
        lut_index_d = lut_index_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
`ifdef ADC_CFG_VERIFY_EN
        raddr_d     = raddr_q;
        rdata_d     = rd_ack ? read_data : rdata_q;
        retry_d     = retry_q;
        err_index_d = err_index_q;
`endif
        case (state_q)
            S_INIT:  cnt_d = cnt_q + CNT_W'(1);
            S_LATCH: begin
                waddr_d = lut_data[20:8];
                wdata_d = lut_data[7:0];
`ifdef ADC_CFG_VERIFY_EN
                raddr_d = lut_data[20:8];
`endif
            end
`ifdef ADC_CFG_VERIFY_EN
            S_CHECK: begin
                if (rd_match)       retry_d     = 4'd0;
                else if (can_retry) retry_d     = retry_q + 4'd1;
                else                err_index_d = lut_index_q;
            end
`endif
            S_NEXT:  if (!last_entry) lut_index_d = lut_index_q + 8'd1;
            default: ;
        endcase

        if (start_ok) begin
            lut_index_d = 8'd0;
`ifdef ADC_CFG_VERIFY_EN
            retry_d     = 4'd0;
            err_index_d = 8'd0;
`endif
        end

        // Requests rise one cycle after entering their state and drop on
        // the ack edge, so a request is never raised while its ack is up.
        cmd_write_d = (state_q == S_WRITE) & ~wr_ack;
`ifdef ADC_CFG_VERIFY_EN
        cmd_read_d  = (state_q == S_READ) & ~rd_ack;
        error_d     = (state_d == S_ERR);
`endif
        // Status flags follow the state being entered so they change on the
        // same edge as the transition.
        busy_d = ~((state_d == S_IDLE) | (state_d == S_DONE) | (state_d == S_ERR));
        done_d = (state_d == S_DONE);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            lut_index_q <= 8'd0;
            waddr_q     <= 13'd0;
            wdata_q     <= 8'd0;
            cmd_write_q <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            lut_index_q <= lut_index_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            cmd_write_q <= cmd_write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef ADC_CFG_VERIFY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr_q     <= 13'd0;
            rdata_q     <= 8'd0;
            retry_q     <= 4'd0;
            cmd_read_q  <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= 8'd0;
        end else begin
            raddr_q     <= raddr_d;
            rdata_q     <= rdata_d;
            retry_q     <= retry_d;
            cmd_read_q  <= cmd_read_d;
            error_q     <= error_d;
            err_index_q <= err_index_d;
        end
    end

    assign cmd_read  = cmd_read_q;
    assign read_addr = raddr_q;
    assign error     = error_q;
    assign err_index = err_index_q;
`else
    logic unused_rd;
    assign unused_rd = ^{read_data, cmd_read_ack};

    assign cmd_read  = 1'b0;
    assign read_addr = 13'd0;
    assign error     = 1'b0;
    assign err_index = 8'd0;
`endif

    assign busy       = busy_q;
    assign done       = done_q;
    assign lut_index  = lut_index_q;
    assign cmd_write  = cmd_write_q;
    assign write_addr = waddr_q;
    assign write_data = wdata_q;

endmodule

// File: tb/tb_adc_cfg_seq.sv
`timescale 1ns/1ps
module tb_adc_cfg_seq;

    localparam int LUT_DEPTH  = 3;
    localparam int INIT_DELAY = 10;
    localparam int MAX_RETRY  = 2;
`ifdef ADC_CFG_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic [7:0]  err_index, lut_index;
    logic [20:0] lut_data = '0;
    logic        cmd_write, cmd_read;
    logic        cmd_write_ack, cmd_read_ack;
    logic [12:0] write_addr, read_addr;
    logic [7:0]  write_data, read_data;

    adc_cfg_seq #(.LUT_DEPTH(LUT_DEPTH), .INIT_DELAY(INIT_DELAY), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .error(error), .err_index(err_index),
        .lut_index(lut_index), .lut_data(lut_data),
        .cmd_write(cmd_write), .cmd_read(cmd_read),
        .cmd_write_ack(cmd_write_ack), .cmd_read_ack(cmd_read_ack),
        .write_addr(write_addr), .write_data(write_data),
        .read_addr(read_addr), .read_data(read_data)
    );

    always #5 clk = ~clk;

    // ---------------- registered ROM ----------------
    logic [20:0] rom [4];
    always @(posedge clk) lut_data <= rom[lut_index[1:0]];

    // ---------------- counters / logs ----------------
    int n_chk = 0;
    int n_fail = 0;
    int proto_err = 0;

    typedef struct packed {
        logic        rd;
        logic [12:0] a;
        logic [7:0]  d;
    } txn_t;
    txn_t obs_q[$];
    txn_t exp_q[$];

    logic [7:0]  regs [8192];
    bit          bad_en = 1'b0;
    logic [12:0] bad_addr = '0;
    int          lat = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- downstream adc_spi model ----------------
    initial begin
        cmd_write_ack = 1'b0;
        cmd_read_ack  = 1'b0;
        read_data     = 8'h00;
        foreach (regs[i]) regs[i] = 8'h00;
        forever begin
            @(negedge clk);
            if (cmd_write && cmd_read) proto_err++;
            if (cmd_write_ack || cmd_read_ack) begin
                // request must have dropped on the ack edge
                if (cmd_write || cmd_read) proto_err++;
                cmd_write_ack = 1'b0;
                cmd_read_ack  = 1'b0;
                lat = -1;
            end else if (!rst_n) begin
                lat = -1;
            end else if (cmd_write || cmd_read) begin
                if (lat < 0) lat = int'($urandom_range(0, 3));
                if (lat == 0) begin
                    if (cmd_write) begin
                        regs[write_addr] = write_data;
                        obs_q.push_back(txn_t'({1'b0, write_addr, write_data}));
                        cmd_write_ack = 1'b1;
                    end else begin
                        read_data = (bad_en && read_addr == bad_addr) ? 8'h00 : regs[read_addr];
                        obs_q.push_back(txn_t'({1'b1, read_addr, read_data}));
                        cmd_read_ack = 1'b1;
                    end
                    lat = -1;
                end else begin
                    lat--;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // Expected bus traffic and final status straight from the table rules.
    task automatic model_run(output bit e_done, output bit e_err,
                             output logic [7:0] e_eidx, output logic [7:0] e_lidx);
        logic [12:0] a;
        logic [7:0]  d, rb;
        exp_q.delete();
        e_done = 1'b1; e_err = 1'b0; e_eidx = 8'd0; e_lidx = 8'(LUT_DEPTH - 1);
        for (int e = 0; e < LUT_DEPTH; e++) begin
            a = rom[e][20:8];
            d = rom[e][7:0];
            if (a == 13'h1FFF) begin
                e_lidx = 8'(e);
                return;
            end
            for (int t = 0; t <= MAX_RETRY; t++) begin
                exp_q.push_back(txn_t'({1'b0, a, d}));
                if (!VERIFY) break;
                rb = (bad_en && a == bad_addr) ? 8'h00 : d;
                exp_q.push_back(txn_t'({1'b1, a, rb}));
                if (rb == d) break;
                if (t == MAX_RETRY) begin
                    e_done = 1'b0; e_err = 1'b1; e_eidx = 8'(e); e_lidx = 8'(e);
                    return;
                end
            end
        end
    endtask

    // ---------------- run helpers ----------------
    // Kick a run (reset release or start pulse) and measure latency to the
    // first cmd_write rise.
    task automatic launch(input string tag, input bit from_reset);
        int n;
        obs_q.delete();
        if (from_reset) begin
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            @(negedge clk);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            chk({tag, "_start_busy"}, busy, 1);
            chk({tag, "_start_done_clr"}, done, 0);
            chk({tag, "_start_err_clr"}, error, 0);
            chk({tag, "_start_lidx0"}, lut_index, 0);
        end
        if (exp_q.size() > 0) begin
            n = 0;
            for (int i = 0; i < 100; i++) begin
                if (!from_reset || i > 0 || n > 0) ;
                @(posedge clk);
                #1;
                n++;
                if (cmd_write) break;
            end
            chk({tag, "_wr_latency"}, n, from_reset ? INIT_DELAY + 3 : 3);
        end
    endtask

    task automatic finish_run(input string tag, output int nw, output int nr);
        bit e_done, e_err;
        logic [7:0] e_eidx, e_lidx;
        int m;
        model_run(e_done, e_err, e_eidx, e_lidx);
        for (int i = 0; i < 3000; i++) begin
            if (!busy) break;
            @(posedge clk);
            #1;
        end
        chk({tag, "_idle_timeout"}, busy, 0);
        chk({tag, "_done"}, done, e_done);
        chk({tag, "_error"}, error, e_err);
        chk({tag, "_err_index"}, err_index, e_err ? e_eidx : 8'd0);
        chk({tag, "_lut_index"}, lut_index, e_lidx);
        chk({tag, "_cmd_idle"}, {cmd_write, cmd_read}, 0);
        chk({tag, "_ntxn"}, obs_q.size(), exp_q.size());
        m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            chk($sformatf("%s_txn%0d", tag, i), obs_q[i], exp_q[i]);
        nw = 0; nr = 0;
        foreach (obs_q[i]) if (obs_q[i].rd) nr++; else nw++;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [20:0] r0, r1, r2;
        bit          bad;
        logic [12:0] baddr;
        int          exp_w, exp_r;
        bit          exp_done, exp_err;
        logic [7:0]  exp_eidx, exp_lidx;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input logic [20:0] r0, r1, r2, input bit bad, input logic [12:0] baddr,
                           input int w, r, input bit dn, er, input logic [7:0] ei, li);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.r2 = r2; v.bad = bad; v.baddr = baddr;
        v.exp_w = w; v.exp_r = r; v.exp_done = dn; v.exp_err = er;
        v.exp_eidx = ei; v.exp_lidx = li;
        vecs.push_back(v);
    endtask

    initial begin
        bit e_done, e_err;
        logic [7:0] e_eidx, e_lidx;
        int nw, nr, k;
        logic [12:0] a;

        // basic 3-entry table
        add_vec({13'h000, 8'h3C}, {13'h014, 8'h01}, {13'h1FE, 8'hA5}, 0, 13'h0,
                3, VERIFY ? 3 : 0, 1, 0, 8'd0, 8'd2);
        // terminator at entry 1
        add_vec({13'h100, 8'h11}, {13'h1FFF, 8'h00}, {13'h022, 8'h33}, 0, 13'h0,
                1, VERIFY ? 1 : 0, 1, 0, 8'd0, 8'd1);
        // entry 2 always reads back 0x00
        add_vec({13'h010, 8'hAA}, {13'h011, 8'hBB}, {13'h012, 8'h55}, 1, 13'h012,
                VERIFY ? 5 : 3, VERIFY ? 5 : 0, !VERIFY, VERIFY, VERIFY ? 8'd2 : 8'd0, 8'd2);
        // terminator at entry 0: no traffic at all
        add_vec({13'h1FFF, 8'h00}, {13'h020, 8'h01}, {13'h021, 8'h02}, 0, 13'h0,
                0, 0, 1, 0, 8'd0, 8'd0);
        // entry 0 fails verify
        add_vec({13'h055, 8'h55}, {13'h056, 8'h66}, {13'h057, 8'h77}, 1, 13'h055,
                VERIFY ? 3 : 3, VERIFY ? 3 : 0, !VERIFY, VERIFY, 8'd0, VERIFY ? 8'd0 : 8'd2);

        rom[3] = '0;
        #1 rst_n = 1'b0;
        #11;
        chk("rst_busy", busy, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_index", err_index, 0);
        chk("rst_lut_index", lut_index, 0);
        chk("rst_cmd_write", cmd_write, 0);
        chk("rst_cmd_read", cmd_read, 0);
        chk("rst_write_addr", write_addr, 0);
        chk("rst_read_addr", read_addr, 0);
        chk("rst_write_data", write_data, 0);

        // table-driven runs; the first comes out of reset
        foreach (vecs[i]) begin
            rom[0] = vecs[i].r0; rom[1] = vecs[i].r1; rom[2] = vecs[i].r2;
            bad_en = vecs[i].bad; bad_addr = vecs[i].baddr;
            model_run(e_done, e_err, e_eidx, e_lidx);
            launch($sformatf("vec%0d", i), i == 0);
            finish_run($sformatf("vec%0d", i), nw, nr);
            chk($sformatf("vec%0d_nwrites", i), nw, vecs[i].exp_w);
            chk($sformatf("vec%0d_nreads", i), nr, vecs[i].exp_r);
            chk($sformatf("vec%0d_tbl_done", i), done, vecs[i].exp_done);
            chk($sformatf("vec%0d_tbl_error", i), error, vecs[i].exp_err);
            chk($sformatf("vec%0d_tbl_eidx", i), err_index, vecs[i].exp_eidx);
            chk($sformatf("vec%0d_tbl_lidx", i), lut_index, vecs[i].exp_lidx);
        end

        // start pulsed mid-run must be ignored
        rom[0] = vecs[0].r0; rom[1] = vecs[0].r1; rom[2] = vecs[0].r2;
        bad_en = 1'b0;
        model_run(e_done, e_err, e_eidx, e_lidx);
        launch("midstart", 1'b0);
        for (int i = 0; i < 200; i++) begin
            if (obs_q.size() >= 1) break;
            @(posedge clk);
            #1;
        end
        chk("midstart_first_txn_seen", obs_q.size() >= 1, 1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("midstart_busy", busy, 1);
        finish_run("midstart", nw, nr);

        // randomized tables against the model
        for (int it = 0; it < 8; it++) begin
            for (int e = 0; e < LUT_DEPTH; e++) begin
                a = 13'($urandom_range(0, 13'h1FFE));
                if ($urandom_range(0, 7) == 0) a = 13'h1FFF;
                rom[e] = {a, 8'($urandom)};
            end
            bad_en = 1'($urandom_range(0, 1));
            k = int'($urandom_range(0, LUT_DEPTH - 1));
            bad_addr = rom[k][20:8];
            model_run(e_done, e_err, e_eidx, e_lidx);
            launch($sformatf("rnd%0d", it), 1'b0);
            finish_run($sformatf("rnd%0d", it), nw, nr);
        end

        // reset during an outstanding cmd_write
        rom[0] = vecs[0].r0; rom[1] = vecs[0].r1; rom[2] = vecs[0].r2;
        bad_en = 1'b0;
        model_run(e_done, e_err, e_eidx, e_lidx);
        launch("rstmid", 1'b0);          // returns just after cmd_write rose
        chk("rstmid_cmd_write_up", cmd_write, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstmid_cmd_write_drop", cmd_write, 0);
        chk("rstmid_busy", busy, 1);
        chk("rstmid_lut_index", lut_index, 0);
        repeat (3) @(negedge clk);
        model_run(e_done, e_err, e_eidx, e_lidx);
        launch("rstmid_rel", 1'b1);
        finish_run("rstmid_rel", nw, nr);

        chk("protocol", proto_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
